// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control sequencer.
// FETCH/DECODE/EXEC/MEM/WB with bus timeout, traps and instret.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic [1:0]       imm_type,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic             bus_err,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [WC_W-1:0] TMO_LAST =
    (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;

  state_t           r_state;
  logic [WC_W-1:0]  r_wait;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;
  logic             r_bus_err;

  logic w_op_r, w_op_i, w_op_ld, w_op_st, w_op_br;
  logic w_f7_zero, w_f7_alt;
  logic w_legal, w_tmo;
  logic [3:0] w_alu;
  logic [1:0] w_imm;
  logic w_src_b;

  logic w_imem_req, w_ir_we, w_dmem_req, w_dmem_we;
  logic w_pc_we, w_pc_sel, w_reg_we, w_wb_sel;
  logic w_retire, w_dec_vis;

  assign w_op_r  = (opcode == 7'b0110011);
  assign w_op_i  = (opcode == 7'b0010011);
  assign w_op_ld = (opcode == 7'b0000011);
  assign w_op_st = (opcode == 7'b0100011);
  assign w_op_br = (opcode == 7'b1100011);

  assign w_f7_zero = (func7 == 7'b0000000);
  assign w_f7_alt  = (func7 == 7'b0100000);

  assign w_tmo = TMO_EN && (r_wait == TMO_LAST);

  // Encoding legality of the instruction held in IR
  always_comb begin
    w_legal = 1'b0;
    unique case (1'b1)
      w_op_r:
        w_legal = w_f7_zero ||
          (w_f7_alt && (func3 == 3'b000 || func3 == 3'b101));
      w_op_i:
        if (func3 == 3'b001)
          w_legal = w_f7_zero;
        else if (func3 == 3'b101)
          w_legal = w_f7_zero || w_f7_alt;
        else
          w_legal = 1'b1;
      w_op_ld:
        w_legal = (func3 != 3'b011) &&
          (func3 != 3'b110) && (func3 != 3'b111);
      w_op_st:
        w_legal = (func3 == 3'b000) ||
          (func3 == 3'b001) || (func3 == 3'b010);
      w_op_br:
        w_legal = (func3 != 3'b010) && (func3 != 3'b011);
      default: w_legal = 1'b0;
    endcase
  end

  // ALU op, immediate format and operand-B select
  always_comb begin
    w_alu = 4'd0;
    case (func3)
      3'b000: w_alu = (w_op_r && func7[5]) ? 4'd1 : 4'd0;
      3'b001: w_alu = 4'd2;
      3'b010: w_alu = 4'd3;
      3'b011: w_alu = 4'd4;
      3'b100: w_alu = 4'd5;
      3'b101: w_alu = func7[5] ? 4'd7 : 4'd6;
      3'b110: w_alu = 4'd8;
      default: w_alu = 4'd9;
    endcase
    if (w_op_ld || w_op_st)
      w_alu = 4'd0;
    if (w_op_br)
      w_alu = 4'd1;
    w_imm = 2'd0;
    if (w_op_st)
      w_imm = 2'd1;
    if (w_op_br)
      w_imm = 2'd2;
    w_src_b = w_op_i || w_op_ld || w_op_st;
  end

  // Per-state control strobes before reset gating
  always_comb begin
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    w_reg_we   = 1'b0;
    w_wb_sel   = 1'b0;
    w_retire   = 1'b0;
    w_dec_vis  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_we    = imem_ready;
      end
      S_DECODE: w_dec_vis = 1'b1;
      S_EXEC: begin
        w_dec_vis = 1'b1;
        if (w_op_br) begin
          w_pc_we  = 1'b1;
          w_pc_sel = br_taken;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        w_dec_vis  = 1'b1;
        w_dmem_req = 1'b1;
        w_dmem_we  = w_op_st;
        if (w_op_st && dmem_ready) begin
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_WB: begin
        w_dec_vis = 1'b1;
        w_reg_we  = 1'b1;
        w_wb_sel  = w_op_ld;
        w_pc_we   = 1'b1;
        w_retire  = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_req  = rst_n & w_imem_req;
  assign ir_we     = rst_n & w_ir_we;
  assign dmem_req  = rst_n & w_dmem_req;
  assign dmem_we   = rst_n & w_dmem_we;
  assign pc_we     = rst_n & w_pc_we;
  assign pc_sel    = rst_n & w_pc_sel;
  assign reg_we    = rst_n & w_reg_we;
  assign wb_sel    = rst_n & w_wb_sel;
  assign retire    = rst_n & w_retire;
  assign alu_src_b = rst_n & w_dec_vis & w_src_b;
  assign alu_ctl   = (rst_n && w_dec_vis) ? w_alu : 4'd0;
  assign imm_type  = (rst_n && w_dec_vis) ? w_imm : 2'd0;
  assign state_o   = rst_n ? r_state : 3'd0;
  assign illegal   = rst_n & r_illegal;
  assign bus_err   = rst_n & r_bus_err;
  assign instret   = rst_n ? r_instret : '0;

  // Sequencing, wait counter, sticky flags and retired count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_retire)
        r_instret <= r_instret + 1'b1;
      r_wait <= '0;
      case (r_state)
        S_FETCH: begin
          if (imem_ready)
            r_state <= S_DECODE;
          else if (w_tmo) begin
            r_bus_err <= 1'b1;
            r_state   <= S_TRAP;
          end else
            r_wait <= r_wait + 1'b1;
        end
        S_DECODE: begin
          if (w_legal)
            r_state <= S_EXEC;
          else begin
            r_illegal <= 1'b1;
            r_state   <= S_TRAP;
          end
        end
        S_EXEC: begin
          if (w_op_br)
            r_state <= S_FETCH;
          else if (w_op_ld || w_op_st)
            r_state <= S_MEM;
          else
            r_state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready)
            r_state <= w_op_st ? S_FETCH : S_WB;
          else if (w_tmo) begin
            r_bus_err <= 1'b1;
            r_state   <= S_TRAP;
          end else
            r_wait <= r_wait + 1'b1;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: scoreboard bench for rv_multicycle_ctrl.
// Driver pushes model expectations; monitor pops on retire/trap/abort.
module tb_rv_multicycle_ctrl;

  localparam int TO = 16;
  localparam int CW = 32;
  localparam int K_RET = 0;
  localparam int K_ILL = 1;
  localparam int K_BUS = 2;
  localparam int K_ABT = 3;
  localparam int ALU_TBL [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic br_taken = 1'b0;
  logic imem_req, imem_ready, ir_we;
  logic dmem_req, dmem_we, dmem_ready;
  logic pc_we, pc_sel, reg_we, wb_sel, alu_src_b;
  logic [3:0] alu_ctl;
  logic [1:0] imm_type;
  logic [2:0] state_o;
  logic illegal, bus_err, retire;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .func3(func3), .func7(func7),
    .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .imm_type(imm_type),
    .state_o(state_o), .illegal(illegal), .bus_err(bus_err),
    .retire(retire), .instret(instret)
  );

  typedef struct {
    int kind;
    int cyc;
    int n_imem;
    int n_irwe;
    int n_dmem;
    int n_regwe;
    int pc_sel;
    int wb_sel;
    int st;
    int alu;
    int imm;
    int srcb;
    int instret;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cur_iw = 0;
  int cur_dw = 0;
  int model_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input int op, input int f3, input int f7);
    case (op)
      'h33: return f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      'h13: begin
        if (f3 == 1) return f7 == 0;
        if (f3 == 5) return f7 == 0 || f7 == 'h20;
        return 1'b1;
      end
      'h03: return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
      'h23: return f3 <= 2;
      'h63: return f3 != 2 && f3 != 3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_alu(input int op, input int f3, input int f7);
    bit alt;
    alt = (f7 / 32) % 2 == 1;
    if (op == 'h03 || op == 'h23) return 0;
    if (op == 'h63) return 1;
    if (f3 == 0 && op == 'h33 && alt) return 1;
    if (f3 == 5 && alt) return 7;
    return ALU_TBL[f3];
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (retire) begin
        k = K_RET;
        break;
      end
      if (state_o == 3'd5) begin
        k = K_ILL;
        break;
      end
    end
    if (k < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no retire or trap within 400 cycles");
      k = K_ILL;
    end
  endtask

  task automatic run_instr(input int op, input int f3, input int f7,
                           input int bt, input int iw, input int dw);
    exp_t e;
    int ks;
    bit ld;
    opcode = 7'(op);
    func3 = 3'(f3);
    func7 = 7'(f7);
    br_taken = (bt != 0);
    cur_iw = iw;
    cur_dw = dw;
    ld = (op == 'h03);
    e = '{default: 0};
    e.instret = model_cnt;
    e.alu = ref_alu(op, f3, f7);
    e.imm = (op == 'h23) ? 1 : (op == 'h63) ? 2 : 0;
    e.srcb = (op == 'h13 || op == 'h03 || op == 'h23) ? 1 : 0;
    e.n_imem = (iw >= TO) ? TO : iw + 1;
    e.n_irwe = (iw >= TO) ? 0 : 1;
    if (iw >= TO) begin
      e.kind = K_BUS;
      e.cyc = TO + 1;
    end else if (!ref_legal(op, f3, f7)) begin
      e.kind = K_ILL;
      e.cyc = iw + 3;
    end else if (op == 'h63) begin
      e.cyc = iw + 3;
      e.pc_sel = (bt != 0) ? 1 : 0;
    end else if (op == 'h33 || op == 'h13) begin
      e.cyc = iw + 4;
      e.n_regwe = 1;
    end else begin
      e.st = ld ? 0 : 1;
      if (dw >= TO) begin
        e.kind = K_BUS;
        e.cyc = iw + TO + 4;
        e.n_dmem = TO;
      end else begin
        e.n_dmem = dw + 1;
        e.cyc = iw + dw + 4 + (ld ? 1 : 0);
        e.n_regwe = ld ? 1 : 0;
        e.wb_sel = ld ? 1 : 0;
      end
    end
    q.push_back(e);
    wait_done(ks);
    if (e.kind == K_RET)
      model_cnt++;
    if (ks != K_RET) begin
      repeat (4) @(negedge clk);
      do_reset();
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_abort();
    exp_t e;
    opcode = 7'h03;
    func3 = 3'd2;
    func7 = 7'd0;
    cur_iw = 0;
    cur_dw = 1000;
    e = '{default: 0};
    e.kind = K_ABT;
    q.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_req) break;
    end
    do_reset();
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 4);
    if (r == 17) return TO - 1;
    if (r == 18) return TO;
    return TO + 5;
  endfunction

  // memory responder: ready after the configured number of wait cycles
  initial begin : responder
    int ic;
    int dc;
    ic = 0;
    dc = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        imem_ready = (ic >= cur_iw);
        ic++;
      end else begin
        imem_ready = 1'b0;
        ic = 0;
      end
      if (dmem_req) begin
        dmem_ready = (dc >= cur_dw);
        dc++;
      end else begin
        dmem_ready = 1'b0;
        dc = 0;
      end
    end
  end

  // monitor: accumulate per-instruction activity, compare on completion
  initial begin : monitor
    int cyc, ni, nirwe, nd, nrw, npc, psel, wbs, st, alu, imm, srcb, tbad, gk;
    bit in_trap, prev_rst, rst_seen;
    exp_t e;
    cyc = 0; ni = 0; nirwe = 0; nd = 0; nrw = 0; npc = 0;
    psel = 0; wbs = 0; st = 0; alu = -1; imm = -1; srcb = -1; tbad = 0;
    in_trap = 0; prev_rst = 0; rst_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (!rst_seen) begin
          rst_seen = 1;
          chk("reset_outputs", {imem_req, ir_we, dmem_req, dmem_we, pc_we,
              pc_sel, reg_we, wb_sel, alu_src_b, alu_ctl, imm_type,
              state_o, illegal, bus_err, retire}, 0);
          chk("reset_instret", instret, 0);
          if (in_trap)
            chk("trap_quiet", tbad, 0);
          else if (cyc > 0 && q.size() > 0 && q[0].kind == K_ABT) begin
            e = q.pop_front();
            chk("abort_reg_we", nrw, 0);
            chk("abort_pc_we", npc, 0);
            chk("abort_in_mem", nd > 0, 1);
          end
        end
        cyc = 0; ni = 0; nirwe = 0; nd = 0; nrw = 0; npc = 0;
        psel = 0; wbs = 0; st = 0; alu = -1; imm = -1; srcb = -1;
        tbad = 0; in_trap = 0;
      end else begin
        rst_seen = 0;
        if (!prev_rst) begin
          chk("post_reset_state", state_o, 0);
          chk("post_reset_instret", instret, 0);
          chk("post_reset_flags", {illegal, bus_err}, 0);
        end
        if (in_trap) begin
          if (state_o != 3'd5 || pc_we || reg_we || retire ||
              ir_we || imem_req || dmem_req)
            tbad++;
        end else begin
          cyc++;
          if (imem_req) ni++;
          if (ir_we) nirwe++;
          if (dmem_req) begin
            nd++;
            if (dmem_we) st = 1;
          end
          if (reg_we) begin
            nrw++;
            wbs = wb_sel;
          end
          if (pc_we) begin
            npc++;
            psel = pc_sel;
          end
          if (state_o == 3'd1) begin
            alu = alu_ctl;
            imm = imm_type;
            srcb = alu_src_b;
          end
          if (retire || state_o == 3'd5) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_completion: state %0d retire %0d",
                       state_o, retire);
              e = '{default: 0};
            end else
              e = q.pop_front();
            if (retire) begin
              chk("completion_kind", K_RET, e.kind);
              chk("latency", cyc, e.cyc);
              chk("imem_req_cycles", ni, e.n_imem);
              chk("ir_we_count", nirwe, e.n_irwe);
              chk("dmem_req_cycles", nd, e.n_dmem);
              chk("dmem_we", st, e.st);
              chk("reg_we_count", nrw, e.n_regwe);
              chk("wb_sel", wbs, e.wb_sel);
              chk("pc_we_count", npc, 1);
              chk("pc_sel", psel, e.pc_sel);
              chk("alu_ctl", alu, e.alu);
              chk("imm_type", imm, e.imm);
              chk("alu_src_b", srcb, e.srcb);
              chk("instret", instret, e.instret);
            end else begin
              gk = illegal ? K_ILL : bus_err ? K_BUS : 99;
              chk("trap_kind", gk, e.kind);
              chk("trap_cycle", cyc, e.cyc);
              chk("trap_imem_cycles", ni, e.n_imem);
              chk("trap_ir_we", nirwe, e.n_irwe);
              chk("trap_dmem_cycles", nd, e.n_dmem);
              chk("trap_reg_we", nrw, 0);
              chk("trap_pc_we", npc, 0);
              in_trap = 1;
            end
            cyc = 0; ni = 0; nirwe = 0; nd = 0; nrw = 0; npc = 0;
            psel = 0; wbs = 0; st = 0; alu = -1; imm = -1; srcb = -1;
          end
        end
      end
      prev_rst = rst_n;
    end
  end

  initial begin : driver
    int op, f3, f7, r;
    do_reset();
    run_instr('h33, 0, 'h00, 0, 0, 0);
    run_instr('h03, 2, 'h00, 0, 3, 0);
    run_instr('h63, 0, 'h00, 1, 0, 0);
    run_instr('h63, 0, 'h00, 0, 0, 0);
    run_instr('h33, 0, 'h20, 0, 0, 0);
    run_instr('h33, 1, 'h20, 0, 0, 0);
    run_instr('h23, 2, 'h00, 0, 0, 1000);
    run_instr('h23, 2, 'h00, 0, 0, TO - 1);
    run_instr('h13, 5, 'h20, 0, TO - 1, 0);
    run_instr('h13, 0, 'h00, 0, TO, 0);
    run_instr('h03, 4, 'h00, 0, 1, 2);
    run_abort();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      op = (r < 4) ? 'h33 : (r < 8) ? 'h13 : (r < 12) ? 'h03 :
           (r < 15) ? 'h23 : (r < 19) ? 'h63 : $urandom_range(0, 127);
      f3 = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      f7 = (r < 6) ? 0 : (r < 9) ? 'h20 : $urandom_range(0, 127);
      run_instr(op, f3, f7, $urandom_range(0, 1), pick_wait(), pick_wait());
    end
    cur_iw = 100000;
    @(negedge clk);
    chk("final_instret", instret, model_cnt);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB around the combinational instruction decoder. From the decoded opcode/func3/func7 it drives the PC, IR, register-file, ALU, immediate-select and data-memory controls. It also handles req/ready handshakes to instruction and data memory, bus timeouts, illegal-instruction traps and the retired-instruction count.

Parameters:
TIMEOUT, 16, max wait cycles for imem/dmem ready before bus error; 0 disables the timeout
CNT_W, 32, width of instret counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  7  from decoder (inst[6:0] of IR)
func3  input  3  from decoder
func7  input  7  from decoder
br_taken  input  1  branch comparator result for current IR
imem_req  output  1  instruction fetch request
imem_ready  input  1  fetch data valid / accepted
ir_we  output  1  load IR from imem data
dmem_req  output  1  data memory request
dmem_we  output  1  1=store, 0=load; valid while dmem_req
dmem_ready  input  1  data access complete
pc_we  output  1  update PC
pc_sel  output  1  0=PC+4, 1=branch target
reg_we  output  1  register-file write enable
wb_sel  output  1  0=ALU result, 1=load data
alu_src_b  output  1  0=rs2, 1=immediate
alu_ctl  output  4  ALU op code (see Behaviour)
imm_type  output  2  0=I, 1=S, 2=B
state_o  output  3  current FSM state
illegal  output  1  sticky illegal-instruction flag
bus_err  output  1  sticky memory-timeout flag
retire  output  1  one-cycle pulse per completed instruction
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0 at clk edge): state<=FETCH, wait counter 0, instret 0, illegal 0, bus_err 0. All outputs are forced to 0 while rst_n=0. Reset mid-instruction abandons it with no pc_we/reg_we.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Outputs are combinational from state and decoder inputs. Any output not listed for a state is 0.
- FETCH: imem_req=1, held until imem_ready. On the ready cycle: ir_we=1, then go to DECODE.
- DECODE: imm_type and alu_ctl become valid. Legal encodings are:
  - R: 0110011, with func7=0000000, or func7=0100000 only when func3 is 000 or 101.
  - I: 0010011. func3=001 requires func7=0000000. func3=101 requires func7 of 0000000 or 0100000.
  - LOAD: 0000011 with func3 in {000,001,010,100,101}.
  - STORE: 0100011 with func3 in {000,001,010}.
  - BRANCH: 1100011 with func3 not 010 or 011.
  - Anything else: set illegal, go to TRAP. Otherwise go to EXEC.
- alu_ctl encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - R: decoded from func3 with func7[5] selecting SUB/SRA.
  - I: decoded from func3; 000 is always ADD; 101 with func7[5] is SRA.
  - LOAD/STORE: ADD.
  - BRANCH: SUB.
- alu_src_b: 1 for I, LOAD and STORE; 0 otherwise.
- imm_type: I for I-type and LOAD, S for STORE, B for BRANCH.
- EXEC:
  - R/I: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_we=1, pc_sel=br_taken, retire=1, then go to FETCH.
- MEM: dmem_req=1, dmem_we=1 for STORE, held until dmem_ready.
  - STORE with ready: pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - LOAD with ready: go to WB.
- WB: reg_we=1, wb_sel=1 for LOAD else 0, pc_we=1, pc_sel=0, retire=1, go to FETCH.
- Timeout: the wait counter increments each FETCH/MEM cycle with req=1 and ready=0, and clears on state change. When the counter equals TIMEOUT-1 and ready is still 0 (TIMEOUT>0): set bus_err, go to TRAP, with no ir_we/pc_we.
  - A ready arriving on that same cycle wins; no error is raised.
- TRAP: all enables 0; state is held until reset. illegal and bus_err clear only on reset.
- instret increments on every retire pulse and wraps modulo 2^CNT_W.
- Latency with zero-wait memory (ready same cycle as req): BRANCH 3 cycles, R/I 4, STORE 4, LOAD 5. Each wait cycle adds one.

Test Plan:
1. Reset, then zero-wait memory, IR=0x002081B3 (add x3,x1,x2): states 0,1,2,4; alu_ctl=0, reg_we=1 in WB; retire at cycle 4; instret=1.
2. Hold imem_ready low for 3 cycles, then run lw (0x0000A183): imem_req held for 4 cycles with ir_we only on the ready cycle; MEM with dmem_we=0; WB with wb_sel=1; instret increments once.
3. Run beq with br_taken=1, then br_taken=0: pc_sel=1 then 0 in EXEC, 3 cycles each, no reg_we.
4. Run IR=0x4000_0033 sub, then func7=0100000 with func3=001: alu_ctl=1 for the sub; the second sets illegal=1, enters TRAP, and stays there with no further pc_we until rst_n=0.
5. TIMEOUT=16 with dmem_ready never asserted on a store: bus_err=1 after 16 MEM cycles, state=5. Repeat with ready arriving on cycle 16: no error, store retires.
6. Assert rst_n=0 during MEM of a load: next state FETCH, instret and flags at 0, no reg_we issued.
